// File: rtl/cpu_exec_pkg.sv
// Shared encodings for the execution core: opcodes, ALU operation codes,
// the halt instruction byte and the decoded control word.
package cpu_exec_pkg;

  localparam int DATA_W = 8;

  // Instruction opcodes (instr[7:4])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hC;
  localparam logic [3:0] OP_ST   = 4'hD;
  localparam logic [3:0] OP_INC  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_NOT    = 4'h5;
  localparam logic [3:0] ALU_SHL    = 4'h6;
  localparam logic [3:0] ALU_SHR    = 4'h7;
  localparam logic [3:0] ALU_PASS_A = 4'h8;
  localparam logic [3:0] ALU_PASS_B = 4'h9;
  localparam logic [3:0] ALU_INC    = 4'hA;

  // Only this exact byte halts; other F-prefixed bytes decode to nothing
  localparam logic [7:0] HLT_INSTR = 8'hF0;

  // Decoded control word
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       use_imm;
    logic       is_two_byte;
    logic       halt;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/cpu_exec_core_if.sv
// Instruction/operand/result bundle between the fetch/register side and the
// execution core. The core uses the slave view; the driver uses master.
interface cpu_exec_core_if;
  import cpu_exec_pkg::*;

  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] next_byte;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [1:0]        reg_dst;
  logic [1:0]        reg_src;
  logic [3:0]        alu_op;
  logic              reg_write;
  logic              mem_write;
  logic              mem_read;
  logic              use_imm;
  logic              is_two_byte;
  logic              halt;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] write_back_data;

  modport master (
    output instr, next_byte, read_data1, read_data2,
    input  reg_dst, reg_src, alu_op, reg_write, mem_write, mem_read,
           use_imm, is_two_byte, halt, alu_result, mem_data, write_back_data
  );

  modport slave (
    input  instr, next_byte, read_data1, read_data2,
    output reg_dst, reg_src, alu_op, reg_write, mem_write, mem_read,
           use_imm, is_two_byte, halt, alu_result, mem_data, write_back_data
  );

endinterface

// File: rtl/exec_alu.sv
// Combinational 8-bit ALU; all arithmetic wraps modulo 256, no flags.
// Undefined operation codes produce zero.
module exec_alu
  import cpu_exec_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  // Select the result for the requested operation
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_AND:    y = a & b;
      ALU_OR:     y = a | b;
      ALU_XOR:    y = a ^ b;
      ALU_NOT:    y = ~a;
      ALU_SHL:    y = {a[DATA_W-2:0], 1'b0};
      ALU_SHR:    y = {1'b0, a[DATA_W-1:1]};
      ALU_PASS_A: y = a;
      ALU_PASS_B: y = b;
      ALU_INC:    y = a + 8'd1;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_exec_core.sv
// Single-cycle execute stage: combinational decode of the instruction byte,
// the ALU, and a small data memory with combinational read and clocked write.
// Reset (active-low, asynchronous) clears the whole memory and holds it clear.
module cpu_exec_core
  import cpu_exec_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst,
  cpu_exec_core_if.slave bus
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  ctrl_t             ctrl;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [AW-1:0]     addr;
  logic              in_range;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_d [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data;

  // Decode the opcode nibble into the control word; unlisted strobes stay 0
  always_comb begin
    ctrl = '0;
    case (bus.instr[7:4])
      OP_NOP:  ctrl = '0;
      OP_ADD:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD;    end
      OP_SUB:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB;    end
      OP_AND:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND;    end
      OP_OR:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;     end
      OP_XOR:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_XOR;    end
      OP_NOT:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_NOT;    end
      OP_SHL:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SHL;    end
      OP_SHR:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SHR;    end
      OP_MOV:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_PASS_B; end
      OP_LDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.use_imm     = 1'b1;
        ctrl.is_two_byte = 1'b1;
        ctrl.alu_op      = ALU_PASS_B;
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.use_imm     = 1'b1;
        ctrl.is_two_byte = 1'b1;
        ctrl.alu_op      = ALU_ADD;
      end
      // Address comes from Rs through operand B
      OP_LD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_op    = ALU_PASS_B;
      end
      // Address comes from Rd through operand A; data is Rs
      OP_ST: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_PASS_A;
      end
      OP_INC:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_INC;    end
      OP_HLT:  ctrl.halt = (bus.instr == HLT_INSTR);
      default: ctrl = '0;
    endcase
  end

  // Operand B is the immediate byte for two-byte instructions
  always_comb begin
    alu_b = ctrl.use_imm ? bus.next_byte : bus.read_data2;
  end

  exec_alu u_alu (
    .op (ctrl.alu_op),
    .a  (bus.read_data1),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Address decode; addresses beyond a reduced memory neither read nor write
  always_comb begin
    addr     = AW'(alu_y);
    in_range = (32'(alu_y) < 32'(MEM_DEPTH));
  end

  // Next memory image: one word replaced by store data on a store
  always_comb begin
    mem_d = mem_q;
    if (ctrl.mem_write && in_range) begin
      mem_d[addr] = bus.read_data2;
    end
  end

  // Memory state; reset clears every word and blocks writes while held low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read sees the pre-edge contents, so a same-cycle write
  // only becomes visible on the following cycle
  always_comb begin
    rd_data = '0;
    if (ctrl.mem_read && in_range) begin
      rd_data = mem_q[addr];
    end
  end

  // Drive the result bundle
  always_comb begin
    bus.reg_dst         = bus.instr[3:2];
    bus.reg_src         = bus.instr[1:0];
    bus.alu_op          = ctrl.alu_op;
    bus.reg_write       = ctrl.reg_write;
    bus.mem_write       = ctrl.mem_write;
    bus.mem_read        = ctrl.mem_read;
    bus.use_imm         = ctrl.use_imm;
    bus.is_two_byte     = ctrl.is_two_byte;
    bus.halt            = ctrl.halt;
    bus.alu_result      = alu_y;
    bus.mem_data        = rd_data;
    bus.write_back_data = ctrl.mem_read ? rd_data : alu_y;
  end

endmodule

// File: tb/tb_cpu_exec_core.sv
// Directed bench for cpu_exec_core with hand-computed expected values.
module tb_cpu_exec_core;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  cpu_exec_core_if bus ();

  cpu_exec_core #(.MEM_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one instruction and let the combinational outputs settle
  task automatic apply(input logic [7:0] ins, input logic [7:0] nb,
                       input logic [7:0] a, input logic [7:0] b);
    bus.instr      = ins;
    bus.next_byte  = nb;
    bus.read_data1 = a;
    bus.read_data2 = b;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {bus.reg_write, bus.mem_write, bus.mem_read,
            bus.use_imm, bus.is_two_byte, bus.halt};
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    apply(8'h00, 8'h00, 8'h00, 8'h00);
    tick();

    // Under reset: memory reads zero, a store is blocked
    apply(8'hC0, 8'h00, 8'h00, 8'h30);
    chk("rst_ld_30", {24'd0, bus.mem_data}, 32'h00);
    apply(8'hD6, 8'h00, 8'h40, 8'h99);
    chk("rst_st_strobe", {26'd0, strobes()}, 32'b010000);
    tick();
    apply(8'hC0, 8'h00, 8'h00, 8'h40);
    chk("rst_st_blocked", {24'd0, bus.mem_data}, 32'h00);

    @(negedge clk);
    rst = 1'b1;
    tick();

    // ADD R1,R2
    apply(8'h16, 8'h00, 8'hF0, 8'h20);
    chk("add_res", {24'd0, bus.alu_result}, 32'h10);
    chk("add_strb", {26'd0, strobes()}, 32'b100000);
    chk("add_wb", {24'd0, bus.write_back_data}, 32'h10);
    chk("add_regs", {28'd0, bus.reg_dst, bus.reg_src}, 32'b0110);
    chk("add_op", {28'd0, bus.alu_op}, 32'h0);

    // LDI
    apply(8'hA4, 8'h5A, 8'h11, 8'h22);
    chk("ldi_res", {24'd0, bus.alu_result}, 32'h5A);
    chk("ldi_strb", {26'd0, strobes()}, 32'b100110);
    chk("ldi_op", {28'd0, bus.alu_op}, 32'h9);

    // ADDI wraps: FF + 02
    apply(8'hB4, 8'h02, 8'hFF, 8'h77);
    chk("addi_res", {24'd0, bus.alu_result}, 32'h01);
    chk("addi_op", {28'd0, bus.alu_op}, 32'h0);

    // ALU corner cases
    apply(8'h20, 8'h00, 8'h00, 8'h01);
    chk("sub_wrap", {24'd0, bus.alu_result}, 32'hFF);
    apply(8'h70, 8'h00, 8'h81, 8'h00);
    chk("shl", {24'd0, bus.alu_result}, 32'h02);
    apply(8'h80, 8'h00, 8'h81, 8'h00);
    chk("shr", {24'd0, bus.alu_result}, 32'h40);
    apply(8'hE0, 8'h00, 8'hFF, 8'h00);
    chk("inc_wrap", {24'd0, bus.alu_result}, 32'h00);
    apply(8'h60, 8'h00, 8'h3C, 8'h00);
    chk("not", {24'd0, bus.alu_result}, 32'hC3);
    apply(8'h31, 8'h00, 8'hF0, 8'h3C);
    chk("and", {24'd0, bus.alu_result}, 32'h30);
    apply(8'h41, 8'h00, 8'hF0, 8'h3C);
    chk("or", {24'd0, bus.alu_result}, 32'hFC);
    apply(8'h51, 8'h00, 8'hF0, 8'h3C);
    chk("xor", {24'd0, bus.alu_result}, 32'hCC);
    apply(8'h91, 8'h00, 8'hF0, 8'h3C);
    chk("mov", {24'd0, bus.alu_result}, 32'h3C);

    // NOP and HLT variants
    apply(8'h00, 8'h00, 8'h12, 8'h34);
    chk("nop_strb", {26'd0, strobes()}, 32'b000000);
    apply(8'hF0, 8'h00, 8'h00, 8'h00);
    chk("hlt_strb", {26'd0, strobes()}, 32'b000001);
    apply(8'hF3, 8'h00, 8'h00, 8'h00);
    chk("f3_strb", {26'd0, strobes()}, 32'b000000);

    // ST then LD of the same address
    apply(8'hD6, 8'h00, 8'h30, 8'h77);
    chk("st_addr", {24'd0, bus.alu_result}, 32'h30);
    chk("st_strb", {26'd0, strobes()}, 32'b010000);
    chk("st_op", {28'd0, bus.alu_op}, 32'h8);
    tick();
    apply(8'hC0, 8'h00, 8'h00, 8'h30);
    chk("ld_strb", {26'd0, strobes()}, 32'b101000);
    chk("ld_data", {24'd0, bus.mem_data}, 32'h77);
    chk("ld_wb", {24'd0, bus.write_back_data}, 32'h77);
    apply(8'hC0, 8'h00, 8'h00, 8'h31);
    chk("ld_other", {24'd0, bus.mem_data}, 32'h00);

    // Overwrite: old value until the edge, new value afterwards
    apply(8'hD6, 8'h00, 8'h30, 8'h55);
    tick();
    apply(8'hC0, 8'h00, 8'h00, 8'h30);
    chk("ld_overwrite", {24'd0, bus.mem_data}, 32'h55);

    // Non-load instruction does not drive mem_data
    apply(8'h16, 8'h00, 8'h30, 8'h00);
    chk("nold_mdata", {24'd0, bus.mem_data}, 32'h00);

    // Asynchronous reset pulse between edges clears memory
    apply(8'hD6, 8'h00, 8'h30, 8'h77);
    tick();
    apply(8'h00, 8'h00, 8'h00, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    apply(8'hC0, 8'h00, 8'h00, 8'h30);
    chk("async_rst_ld", {24'd0, bus.mem_data}, 32'h00);
    tick();
    chk("async_rst_ld2", {24'd0, bus.write_back_data}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
